// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: instruction fetch/dispatch sequencer for the CPU front end.
// Define FETCH_INSTR_CNT_EN to build the retired-instruction counter on instr_cnt.
module instr_fetch_ctrl #(
  parameter int PC_W = 9,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            halt,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [15:0]     mem_rdata,
  output logic            ir_load,
  output logic [15:0]     ir_data,
  output logic            exec_s,
  input  logic            exec_w,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic [15:0]     instr_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, LOAD, DISPATCH, EXEC} state_t;
  state_t state, state_nx;
  logic exec_first;
  logic done;
  // exec_w is not trusted in the first EXEC cycle; the execute FSM needs a cycle to react to exec_s
  assign done = state == EXEC && !exec_first && exec_w;
  assign mem_addr = pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      exec_first <= 1'b0;
    end else begin
      state <= state_nx;
      exec_first <= state == DISPATCH;
    end
  end
  always_comb begin
    state_nx = state;
    mem_rd = 1'b0;
    ir_load = 1'b0;
    exec_s = 1'b0;
    busy = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        state_nx = !pc_load && run && !halt ? FETCH : IDLE;
      end
      FETCH: begin
        mem_rd = 1'b1;
        state_nx = WAIT_MEM;
      end
      WAIT_MEM: begin
        mem_rd = 1'b1;
        state_nx = mem_ready ? LOAD : WAIT_MEM;
      end
      LOAD: begin
        ir_load = 1'b1;
        state_nx = DISPATCH;
      end
      DISPATCH: begin
        exec_s = 1'b1;
        state_nx = EXEC;
      end
      EXEC: state_nx = !done ? EXEC : (halt || !run) ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) pc <= RST_PC;
    else if (state == IDLE && pc_load) pc <= pc_in;
    else if (state == LOAD) pc <= pc + PC_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) ir_data <= '0;
    else if (state == WAIT_MEM && mem_ready) ir_data <= mem_rdata;
  end
`ifdef FETCH_INSTR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) instr_cnt <= '0;
    else if (done) instr_cnt <= instr_cnt + 16'd1;
  end
`else
  assign instr_cnt = '0;
`endif
endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter: PC_W, 9, program-counter width in bits.
REQ-002 SHALL have parameter: RST_PC, 0, PC value loaded on reset.
REQ-003 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: run  input  1  level; start/continue fetching from IDLE.
REQ-006 SHALL have port: halt  input  1  level; stop after current instruction completes.
REQ-007 SHALL have ports: pc_load  input  1 and pc_in  input  PC_W; overwrite PC, honoured only in IDLE.
REQ-008 SHALL have ports: mem_rd  output  1, mem_addr  output  PC_W, mem_ready  input  1, mem_rdata  input  16; instruction-memory read handshake.
REQ-009 SHALL have ports: ir_load  output  1, ir_data  output  16; drive the CPU instruction-register load and data.
REQ-010 SHALL have ports: exec_s  output  1, exec_w  input  1; start pulse to and wait flag from the execute FSM.
REQ-011 SHALL have ports: pc  output  PC_W, busy  output  1, instr_cnt  output  16.

Function
REQ-012 SHALL implement states IDLE, FETCH, WAIT_MEM, LOAD, DISPATCH, EXEC.
REQ-013 IDLE: busy=0; if pc_load, PC<=pc_in; else if run=1 and halt=0, go FETCH; pc_load has priority over run in the same cycle.
REQ-014 FETCH: mem_rd=1, mem_addr=PC for exactly one cycle; go WAIT_MEM.
REQ-015 WAIT_MEM: mem_rd=1, mem_addr held at PC; on mem_ready=1 capture mem_rdata into ir_data register, go LOAD; otherwise stay (no timeout).
REQ-016 LOAD: ir_load=1 for one cycle; PC<=PC+1 modulo 2^PC_W (all-ones wraps to 0); go DISPATCH.
REQ-017 DISPATCH: exec_s=1 for exactly one cycle; go EXEC.
REQ-018 EXEC: ignore exec_w in first EXEC cycle; thereafter on exec_w=1 the instruction is complete.
REQ-019 On completion: if halt=1 or run=0, go IDLE; else go FETCH (no idle cycle between instructions).
REQ-020 halt asserted in any state other than EXEC completion SHALL NOT abort the in-flight fetch/execute.
REQ-021 mem_rd, ir_load, exec_s SHALL be 0 in every state not listed as asserting them; busy=1 in all states except IDLE.
REQ-022 ir_data SHALL change only on mem_ready capture in WAIT_MEM; holds value otherwise.
REQ-023 Minimum instruction latency: FETCH(1)+WAIT_MEM(1 with mem_ready=1)+LOAD(1)+DISPATCH(1)+EXEC(>=2) = 6 cycles.
REQ-024 pc output SHALL reflect the PC register directly (next fetch address after LOAD).

Reset
REQ-025 On clk edge with reset=1: state=IDLE, PC=RST_PC, ir_data=0, instr_cnt=0, mem_rd=ir_load=exec_s=busy=0.
REQ-026 reset SHALL override every state including mid-WAIT_MEM and EXEC; a pending mem_ready in that cycle is discarded.
REQ-027 reset SHALL take priority over pc_load and run in the same cycle.

Configuration
REQ-028 Macro FETCH_INSTR_CNT_EN defined: instr_cnt increments by 1 on each EXEC completion, wraps 16'hFFFF->0, cleared by reset.
REQ-029 Macro FETCH_INSTR_CNT_EN undefined: instr_cnt tied to 16'h0000, no counter flops synthesized; all other behaviour identical.

Verification
REQ-030 Reset, run=1, mem_ready=1, mem_rdata=16'hD105, exec_w high from 2nd EXEC cycle -> mem_addr=0, ir_data=16'hD105, ir_load cycle 3, exec_s cycle 4, pc=1, next FETCH at cycle 7.
REQ-031 pc_load=1, pc_in=9'h1FF in IDLE, then run -> fetch at 0x1FF, pc wraps to 0x000 after LOAD.
REQ-032 mem_ready held 0 for 5 cycles in WAIT_MEM -> mem_rd and mem_addr stable 5 cycles, no ir_load, then capture on 6th.
REQ-033 halt pulsed during WAIT_MEM, held through EXEC completion -> instruction completes, return to IDLE, busy=0, pc advanced by 1.
REQ-034 reset asserted in EXEC -> next cycle IDLE, pc=RST_PC, instr_cnt=0, exec_s never re-asserted.
REQ-035 With FETCH_INSTR_CNT_EN, 3 back-to-back instructions -> instr_cnt=3; without macro -> instr_cnt=0.
